// File: rtl/reg_writeback.sv
// reg_writeback
// Owns the register file's single write port. Results from the ALU and the
// load unit arrive over valid/ready handshakes and are arbitrated
// round-robin, at most one per cycle. The accepted result is registered and
// presented to the register file as a one-cycle write pulse. A per-register
// pending scoreboard tracks issued-but-not-yet-written destinations.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/addr/data, alu_ready  ALU result handshake
//   mem_valid/addr/data, mem_ready  load result handshake
//   issue_en, issue_addr          instruction issue, marks destination pending
//   issue_ready                   destination not pending, issue accepted
//   write_en/addr/data            registered register-file write port
//   pending                       scoreboard, bit i = register i outstanding
//   err_orphan                    sticky: result accepted for non-pending reg
module reg_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_ready,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    output logic                         issue_ready,
    output logic                         write_en,
    output logic [ADDR_WIDTH-1:0]        write_addr,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending,
    output logic                         err_orphan
);

    localparam int REG_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e                  last_grant_q;
    grant_e                  last_grant_d;
    logic                    write_en_q;
    logic                    write_en_d;
    logic [ADDR_WIDTH-1:0]   write_addr_q;
    logic [ADDR_WIDTH-1:0]   write_addr_d;
    logic [DATA_WIDTH-1:0]   write_data_q;
    logic [DATA_WIDTH-1:0]   write_data_d;
    logic [REG_DEPTH-1:0]    pending_q;
    logic [REG_DEPTH-1:0]    pending_d;
    logic                    err_orphan_q;
    logic                    err_orphan_d;

    logic                    xfer;
    logic [ADDR_WIDTH-1:0]   xfer_addr;
    logic [DATA_WIDTH-1:0]   xfer_data;
    logic                    xfer_is_zero;
    logic                    issue_is_zero;
    logic                    issue_set;

    // Arbitration: a lone valid always wins; on a tie the source that did
    // not win the previous transfer goes first.
    always_comb begin
        alu_ready = alu_valid & (~mem_valid | (last_grant_q == GRANT_MEM));
        mem_ready = mem_valid & (~alu_valid | (last_grant_q == GRANT_ALU));
    end

    assign xfer          = alu_ready | mem_ready;
    assign xfer_addr     = alu_ready ? alu_addr : mem_addr;
    assign xfer_data     = alu_ready ? alu_data : mem_data;
    assign xfer_is_zero  = (ZERO_REG != 0) && (xfer_addr == '0);
    assign issue_is_zero = (ZERO_REG != 0) && (issue_addr == '0);

    // The hard-wired zero register can always be issued against and is
    // never tracked.
    assign issue_ready = issue_is_zero | ~pending_q[issue_addr];
    assign issue_set   = issue_en & issue_ready & ~issue_is_zero;

    always_comb begin
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        err_orphan_d = err_orphan_q;
        if (xfer) begin
            last_grant_d = alu_ready ? GRANT_ALU : GRANT_MEM;
            // A result to the zero register still handshakes but is discarded.
            write_en_d   = ~xfer_is_zero;
            write_addr_d = xfer_addr;
            write_data_d = xfer_data;
            if (!xfer_is_zero && !pending_q[xfer_addr]) begin
                err_orphan_d = 1'b1;
            end
        end
    end

    // Scoreboard: a bit clears at the edge that ends its write pulse and sets
    // on an accepted issue. The same bit cannot see both at once because
    // issue_ready is low while it is set.
    for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_pending
        if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign pending_d[gi] = 1'b0;
        end else begin : g_bit
            assign pending_d[gi] =
                (pending_q[gi] & ~(write_en_q && (write_addr_q == ADDR_WIDTH'(gi))))
                | (issue_set && (issue_addr == ADDR_WIDTH'(gi)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_MEM;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            pending_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            pending_q    <= pending_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign pending    = pending_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_reg_writeback.sv
`timescale 1ns/1ps
// Testbench for reg_writeback: directed stimulus, a transaction-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_reg_writeback;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          issue_en = 1'b0;
    logic [AW-1:0] issue_addr = '0;
    logic          issue_ready;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [DEPTH-1:0] pending;
    logic          err_orphan;

    reg_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .pending(pending), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // State: set of outstanding registers, sticky error, who won last, and
    // the single write that is due to appear on the port this cycle.
    bit            m_pend [DEPTH];
    bit            m_err;
    bit            m_last_alu;
    bit            m_wr_v;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit            n_pend [DEPTH];
    bit            n_err;
    bit            n_last_alu;
    bit            n_wr_v;
    logic [AW-1:0] n_wr_addr;
    logic [DW-1:0] n_wr_data;

    always @(negedge clk) begin
        logic [DEPTH-1:0] pv;
        bit               e_alu;
        bit               e_mem;
        bit               e_iss;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        if (!rst_n) begin
            chk("rst_write_en", write_en, 0);
            chk("rst_write_addr", write_addr, 0);
            chk("rst_write_data", write_data, 0);
            chk("rst_pending", pending, 0);
            chk("rst_err_orphan", err_orphan, 0);
            for (int i = 0; i < DEPTH; i++) begin
                m_pend[i] = 0;
                n_pend[i] = 0;
            end
            m_err = 0; n_err = 0;
            m_last_alu = 0; n_last_alu = 0;   // load counts as last winner
            m_wr_v = 0; n_wr_v = 0;
            m_wr_addr = '0; n_wr_addr = '0;
            m_wr_data = '0; n_wr_data = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) pv[i] = m_pend[i];
            if (alu_valid && mem_valid) begin
                e_alu = !m_last_alu;
                e_mem = m_last_alu;
            end else begin
                e_alu = alu_valid;
                e_mem = mem_valid;
            end
            e_iss = (issue_addr == 0) ? 1'b1 : !m_pend[issue_addr];

            chk("m_alu_ready", alu_ready, e_alu);
            chk("m_mem_ready", mem_ready, e_mem);
            chk("m_issue_ready", issue_ready, e_iss);
            chk("m_write_en", write_en, m_wr_v);
            if (m_wr_v) begin
                chk("m_write_addr", write_addr, m_wr_addr);
                chk("m_write_data", write_data, m_wr_data);
            end
            chk("m_pending", pending, pv);
            chk("m_err_orphan", err_orphan, m_err);

            // next state
            for (int i = 0; i < DEPTH; i++) n_pend[i] = m_pend[i];
            n_err = m_err;
            n_last_alu = m_last_alu;
            n_wr_v = 0;
            n_wr_addr = m_wr_addr;
            n_wr_data = m_wr_data;
            if (m_wr_v) n_pend[m_wr_addr] = 0;
            if (issue_en && e_iss && issue_addr != 0) n_pend[issue_addr] = 1;
            if (e_alu || e_mem) begin
                a = e_alu ? alu_addr : mem_addr;
                d = e_alu ? alu_data : mem_data;
                $display("[TB] xfer src=%s addr=%0d data=0x%04h", e_alu ? "ALU" : "MEM", a, d);
                n_last_alu = e_alu;
                n_wr_addr = a;
                n_wr_data = d;
                if (a != 0) begin
                    n_wr_v = 1;
                    if (!m_pend[a]) n_err = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_pend[i] = n_pend[i];
            m_err = n_err;
            m_last_alu = n_last_alu;
            m_wr_v = n_wr_v;
            m_wr_addr = n_wr_addr;
            m_wr_data = n_wr_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0; issue_en = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_alu;
        bit got_mem;
        int ai;
        int li;
        int wcount;

        // Reset then idle
        do_reset();
        @(negedge clk);
        chk("idle_alu_ready", alu_ready, 0);
        chk("idle_mem_ready", mem_ready, 0);
        chk("idle_write_en", write_en, 0);
        chk("idle_pending", pending, 0);
        chk("idle_err", err_orphan, 0);
        for (int a = 0; a < DEPTH; a++) begin
            issue_addr = AW'(a);
            #0.1;
            chk("idle_issue_ready", issue_ready, 1);
        end
        step();

        // Round-robin: pre-issue r1..r4 and r6..r9
        for (int k = 0; k < 8; k++) begin
            issue_en = 1;
            issue_addr = AW'(k < 4 ? k + 1 : k + 2);
            step();
        end
        issue_en = 0;
        ai = 0; li = 0; wcount = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = (ai < 4);
            alu_addr  = AW'(ai + 1);
            alu_data  = DW'(16'hA000 + ai + 1);
            mem_valid = (li < 4);
            mem_addr  = AW'(li + 6);
            mem_data  = DW'(16'hB000 + li + 6);
            @(negedge clk);
            chk("rr_alu_grant", alu_ready, (c % 2) == 0);
            chk("rr_mem_grant", mem_ready, (c % 2) == 1);
            if (write_en) wcount++;
            got_alu = alu_ready;
            got_mem = mem_ready;
            step();
            if (got_alu) ai++;
            if (got_mem) li++;
        end
        alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        if (write_en) wcount++;
        chk("rr_last_addr", write_addr, 9);
        chk("rr_last_data", write_data, 16'hB009);
        chk("rr_write_cycles", wcount, 8);
        step();
        @(negedge clk);
        chk("rr_drained_we", write_en, 0);
        chk("rr_drained_pending", pending, 0);
        step();

        // Issue r5, ALU result r5=0x1234 two cycles later
        issue_en = 1; issue_addr = 5;
        step();
        issue_en = 0;
        step();
        alu_valid = 1; alu_addr = 5; alu_data = 16'h1234;
        @(negedge clk);
        chk("r5_alu_ready", alu_ready, 1);
        chk("r5_pending_set", pending, 32'h20);
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("r5_write_en", write_en, 1);
        chk("r5_write_addr", write_addr, 5);
        chk("r5_write_data", write_data, 16'h1234);
        step();
        issue_addr = 5;
        @(negedge clk);
        chk("r5_write_en_off", write_en, 0);
        chk("r5_pending_clr", pending[5], 0);
        chk("r5_issue_ready", issue_ready, 1);
        chk("r5_err", err_orphan, 0);
        step();

        // Double issue of r7, held until writeback frees it
        issue_en = 1; issue_addr = 7;
        step();
        @(negedge clk);
        chk("r7_reissue_blocked", issue_ready, 0);
        chk("r7_pending", pending, 32'h80);
        step();
        @(negedge clk);
        chk("r7_pending_held", pending, 32'h80);
        alu_valid = 1; alu_addr = 7; alu_data = 16'h0777;
        #0.1;
        chk("r7_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("r7_write_en", write_en, 1);
        chk("r7_issue_wait", issue_ready, 0);
        step();
        @(negedge clk);
        chk("r7_issue_free", issue_ready, 1);
        chk("r7_pending_clr", pending[7], 0);
        step();
        issue_en = 0;
        @(negedge clk);
        chk("r7_reissued", pending[7], 1);
        step();

        // Zero register
        issue_en = 1; issue_addr = 0;
        @(negedge clk);
        chk("r0_issue_ready", issue_ready, 1);
        step();
        issue_en = 0;
        alu_valid = 1; alu_addr = 0; alu_data = 16'hFFFF;
        @(negedge clk);
        chk("r0_not_pending", pending[0], 0);
        chk("r0_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("r0_no_write", write_en, 0);
        chk("r0_err", err_orphan, 0);
        step();

        // Orphan loads to r3 and r10, reset during the second write
        mem_valid = 1; mem_addr = 3; mem_data = 16'h00AA;
        @(negedge clk);
        chk("orph_mem_ready", mem_ready, 1);
        step();
        mem_addr = 10; mem_data = 16'h00BB;
        @(negedge clk);
        chk("orph_write_en", write_en, 1);
        chk("orph_write_addr", write_addr, 3);
        chk("orph_write_data", write_data, 16'h00AA);
        chk("orph_err_set", err_orphan, 1);
        step();
        mem_valid = 0;
        @(negedge clk);
        chk("orph2_write_en", write_en, 1);
        chk("orph2_write_addr", write_addr, 10);
        chk("orph_err_sticky", err_orphan, 1);
        #1 rst_n = 0;
        #1;
        chk("arst_write_en", write_en, 0);
        chk("arst_err", err_orphan, 0);
        chk("arst_pending", pending, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_write_en", write_en, 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
